// File: rtl/fixed_32_seq_div_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fixed_32_seq_div_if : operand/result handshake bundle for fixed_32_seq_div
// Rev 1.0
// ---------------------------------------------------------------------------
interface fixed_32_seq_div_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] dividend_in;
  logic [DATA_W-1:0] divisor_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] quotient_out;
  logic              overflow;
  logic              div_by_zero;
  logic              busy;

  modport master (
    output in_valid, dividend_in, divisor_in, out_ready,
    input  in_ready, out_valid, quotient_out, overflow, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend_in, divisor_in, out_ready,
    output in_ready, out_valid, quotient_out, overflow, div_by_zero, busy
  );
endinterface
`default_nettype wire

// File: rtl/fixed_32_seq_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fixed_32_seq_div : signed Q24.8 restoring divider, one quotient bit per clock
// Rev 1.0
// ---------------------------------------------------------------------------
module fixed_32_seq_div #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  fixed_32_seq_div_if.slave bus
);

  localparam int NUM_W = DATA_W + FRAC_W;
  localparam int CNT_W = $clog2(NUM_W);
  localparam logic [CNT_W-1:0]  CNT_START = CNT_W'(NUM_W - 1);
  localparam logic [DATA_W-1:0] MAX_POS   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [NUM_W-1:0]  POS_LIMIT = {{FRAC_W{1'b0}}, MAX_POS};
  localparam logic [NUM_W-1:0]  NEG_LIMIT = {{FRAC_W{1'b0}}, MIN_NEG};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic              sign;
  logic [DATA_W-1:0] dmag;
  logic [NUM_W-1:0]  num;
  logic [DATA_W-1:0] rem;
  logic [NUM_W-1:0]  q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] quotient;
  logic              ovf;
  logic              dbz;

  logic              div_zero_in;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   rem_diff;
  logic              rem_ge;
  logic              q_over;
  logic [DATA_W-1:0] q_signed;

  // Magnitudes are unsigned, so -(-2^31) correctly becomes 2^31.
  assign div_zero_in = (bus.divisor_in == '0);
  assign a_mag       = bus.dividend_in[DATA_W-1] ? -bus.dividend_in : bus.dividend_in;
  assign b_mag       = bus.divisor_in[DATA_W-1]  ? -bus.divisor_in  : bus.divisor_in;

  // rem < |b| <= 2^31 always, so after the shift a borrow out of bit DATA_W means rem < |b|.
  assign rem_shift = {rem, num[NUM_W-1]};
  assign rem_diff  = rem_shift - {1'b0, dmag};
  assign rem_ge    = ~rem_diff[DATA_W];

  assign q_over   = sign ? (q > NEG_LIMIT) : (q > POS_LIMIT);
  assign q_signed = sign ? -q[DATA_W-1:0] : q[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = div_zero_in ? DONE : CALC;
      CALC:    if (cnt == '0) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign     <= 1'b0;
      dmag     <= '0;
      num      <= '0;
      rem      <= '0;
      q        <= '0;
      cnt      <= '0;
      quotient <= '0;
      ovf      <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign <= bus.dividend_in[DATA_W-1] ^ bus.divisor_in[DATA_W-1];
            dmag <= b_mag;
            num  <= {a_mag, {FRAC_W{1'b0}}};
            rem  <= '0;
            q    <= '0;
            cnt  <= CNT_START;
            if (div_zero_in) begin
              quotient <= bus.dividend_in[DATA_W-1] ? MIN_NEG : MAX_POS;
              dbz      <= 1'b1;
              ovf      <= 1'b0;
            end
          end
        end
        CALC: begin
          rem <= rem_ge ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
          q   <= {q[NUM_W-2:0], rem_ge};
          num <= {num[NUM_W-2:0], 1'b0};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          quotient <= q_over ? (sign ? MIN_NEG : MAX_POS) : q_signed;
          ovf      <= q_over;
          dbz      <= 1'b0;
        end
        DONE: begin
          if (bus.out_ready) begin
            ovf <= 1'b0;
            dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.out_valid    = (state == DONE);
  assign bus.quotient_out = quotient;
  assign bus.overflow     = ovf;
  assign bus.div_by_zero  = dbz;

endmodule
`default_nettype wire

// File: tb/tb_fixed_32_seq_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fixed_32_seq_div : directed vectors for fixed_32_seq_div with a reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fixed_32_seq_div;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fixed_32_seq_div_if #(.DATA_W(32)) bus ();

  fixed_32_seq_div #(.DATA_W(32), .FRAC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m_q;
  logic        m_ovf;
  logic        m_dbz;
  bit          m_armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: exact signed division of a*2^8 by b, truncated toward zero, then saturated.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic ovf, output logic dbz);
    longint na, nb, qq;
    if (b == 32'd0) begin
      dbz = 1'b1;
      ovf = 1'b0;
      q   = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      dbz = 1'b0;
      na  = longint'($signed(a)) * 64'sd256;
      nb  = longint'($signed(b));
      qq  = na / nb;
      if (qq > 64'sd2147483647) begin
        ovf = 1'b1;
        q   = 32'h7FFF_FFFF;
      end else if (qq < -64'sd2147483648) begin
        ovf = 1'b1;
        q   = 32'h8000_0000;
      end else begin
        ovf = 1'b0;
        q   = qq[31:0];
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("ready_vs_busy", bus.in_ready, !bus.busy);
      if (bus.out_valid) begin
        check("ready_in_done", bus.in_ready, 0);
        if (m_armed) begin
          check("cmp_quotient", bus.quotient_out, m_q);
          check("cmp_overflow", bus.overflow, m_ovf);
          check("cmp_div_by_zero", bus.div_by_zero, m_dbz);
        end
      end else begin
        check("flags_when_idle", {bus.overflow, bus.div_by_zero}, 0);
      end
    end
  end

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_q,
                     input logic exp_ovf, input logic exp_dbz, input int exp_lat,
                     input int hold, input bit poke);
    logic [31:0] mq;
    logic        mo, md;
    int          n;
    model(a, b, mq, mo, md);
    check("model_pin_q", mq, exp_q);
    check("model_pin_flags", {mo, md}, {exp_ovf, exp_dbz});
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #2; n++;
    end
    bus.dividend_in = a;
    bus.divisor_in  = b;
    bus.in_valid    = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        m_q = mq; m_ovf = mo; m_dbz = md; m_armed = 1'b1;
      end
      if (poke && n >= 3 && n < 10) begin
        bus.in_valid    = 1'b1;
        bus.dividend_in = 32'h1234_5678;
        bus.divisor_in  = 32'h0000_0100;
      end else begin
        bus.in_valid = 1'b0;
      end
    end while (!bus.out_valid && n < 100);
    bus.in_valid = 1'b0;
    check("latency", n, exp_lat);
    check("result_q", bus.quotient_out, exp_q);
    check("result_flags", {bus.overflow, bus.div_by_zero}, {exp_ovf, exp_dbz});
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.in_valid    = 1'b1;
        bus.dividend_in = 32'h0000_0500;
        bus.divisor_in  = 32'h0000_0300;
      end
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid, 1);
      check("hold_q", bus.quotient_out, exp_q);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    m_armed = 1'b0;
    check("release_valid", bus.out_valid, 0);
    check("release_ready", bus.in_ready, 1);
    check("release_flags", {bus.overflow, bus.div_by_zero}, 0);
    check("release_q_kept", bus.quotient_out, exp_q);
    #1;
  endtask

  task automatic reset_mid_calc();
    bus.dividend_in = 32'h0000_0A00;
    bus.divisor_in  = 32'h0000_0400;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("pre_reset_busy", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_q", bus.quotient_out, 0);
    check("abort_flags", {bus.overflow, bus.div_by_zero}, 0);
    #1;
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.dividend_in = '0;
    bus.divisor_in  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", bus.quotient_out, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_flags", {bus.overflow, bus.div_by_zero}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_busy", bus.busy, 0);
    #1;

    run(32'h0000_0A00, 32'h0000_0400, 32'h0000_0280, 1'b0, 1'b0, 42, 0, 1'b0);
    run(32'hFFFF_F880, 32'h0000_0200, 32'hFFFF_FC40, 1'b0, 1'b0, 42, 0, 1'b0);
    run(32'h0000_0100, 32'h0000_0300, 32'h0000_0055, 1'b0, 1'b0, 42, 0, 1'b0);
    run(32'hFFFF_FF00, 32'h0000_0300, 32'hFFFF_FFAB, 1'b0, 1'b0, 42, 0, 1'b0);
    run(32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 42, 0, 1'b0);
    run(32'h8000_0000, 32'h0000_0100, 32'h8000_0000, 1'b0, 1'b0, 42, 0, 1'b0);
    run(32'h8000_0000, 32'hFFFF_FF00, 32'h7FFF_FFFF, 1'b1, 1'b0, 42, 0, 1'b0);
    run(32'h0000_0100, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1, 0, 1'b0);
    run(32'hFFFF_FF00, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 1, 0, 1'b0);
    run(32'h0000_3200, 32'hFFFF_FB00, 32'hFFFF_F600, 1'b0, 1'b0, 42, 10, 1'b1);
    run(32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1, 3, 1'b1);
    run(32'hFFFF_FF00, 32'h0000_0100, 32'hFFFF_FF00, 1'b0, 1'b0, 42, 0, 1'b0);
    reset_mid_calc();
    run(32'h0000_0A00, 32'h0000_0400, 32'h0000_0280, 1'b0, 1'b0, 42, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
